// File: rtl/psum_rb_pkg.sv
// Shared types and defaults for the partial-sum read-back buffer.
package psum_rb_pkg;

  localparam int DW_DEF    = 64;
  localparam int AW_DEF    = 4;
  localparam int DEPTH_DEF = 4;
  localparam int ROW_IDX_W = 2;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, READY} state_t;

  // Index of the last row for a requested total; totals above 4 clamp to row 3.
  function automatic logic [ROW_IDX_W-1:0] last_idx(input logic [2:0] total);
    if (total >= 3'd4) return 2'd3;
    return total[1:0] - 2'd1;
  endfunction

endpackage

// File: rtl/psum_rd_pipe.sv
// Read-latency tracker: RD_LAT-deep shift of {valid, row_idx} that strobes bank captures.
module psum_rd_pipe
  import psum_rb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic                 IN_VALID,
  input  logic [ROW_IDX_W-1:0] IN_IDX,
  output logic                 OUT_VALID,
  output logic [ROW_IDX_W-1:0] OUT_IDX
);

  logic [RD_LAT-1:0]    vld_q;
  logic [ROW_IDX_W-1:0] idx_q [RD_LAT];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
    end else if (CLR) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= IN_VALID;
      idx_q[0] <= IN_IDX;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign OUT_VALID = vld_q[RD_LAT-1];
  assign OUT_IDX   = idx_q[RD_LAT-1];

endmodule

// File: rtl/psum_rbuffer.sv
// Partial-sum read-back buffer: fetches up to 4 rows from output memory and serves them show-ahead.
// Optional zero-fill first tile support via PSUM_RB_FIRST_TILE_EN.
//
// state | meaning
// IDLE  | waiting for START with a non-zero row total
// FETCH | issuing one memory read per cycle
// WAIT  | draining read latency until the last row is captured
// READY | presenting bank[rcnt] to the consumer until the last pop
module psum_rbuffer
  import psum_rb_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR_DP,
  input  logic          START,
  input  logic [AW-1:0] BASE_ADDR,
  input  logic [2:0]    ROW_TOTAL,
`ifdef PSUM_RB_FIRST_TILE_EN
  input  logic          FIRST_TILE,
`endif
  output logic [AW-1:0] OSRC_rb,
  output logic          REN_rb,
  input  logic [DW-1:0] RData,
  output logic          FETCH_DONE,
  output logic          PSUM_VALID,
  output logic [DW-1:0] PSUM,
  input  logic          POP,
  output logic          DRAIN_DONE,
  output logic          BUSY
);

  state_t               state_q, state_d;
  logic [ROW_IDX_W-1:0] icnt_q, wcnt_q, rcnt_q, last_q;
  logic [AW-1:0]        base_q;
  logic [DW-1:0]        bank_q [DEPTH];
  logic                 fetch_done_q, drain_done_q;
  logic                 first_tile_w, start_ok;
  logic                 cap_valid;
  logic [ROW_IDX_W-1:0] cap_idx;

`ifdef PSUM_RB_FIRST_TILE_EN
  assign first_tile_w = FIRST_TILE;
`else
  assign first_tile_w = 1'b0;
`endif

  assign start_ok = START && (ROW_TOTAL != 3'd0);

  psum_rd_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .CLK       (CLK),
    .RST       (RST),
    .CLR       (CLR_DP),
    .IN_VALID  (REN_rb),
    .IN_IDX    (icnt_q),
    .OUT_VALID (cap_valid),
    .OUT_IDX   (cap_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    REN_rb  = 1'b0;
    OSRC_rb = '0;
    case (state_q)
      IDLE:  if (start_ok) state_d = first_tile_w ? READY : FETCH;
      FETCH: begin
        REN_rb  = 1'b1;
        OSRC_rb = base_q + AW'(icnt_q);
        if (icnt_q == last_q) state_d = WAIT;
      end
      WAIT:  if (cap_valid && wcnt_q == last_q) state_d = READY;
      READY: if (POP && rcnt_q == last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (CLR_DP) state_d = IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icnt_q       <= '0;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      last_q       <= '0;
      base_q       <= '0;
      fetch_done_q <= 1'b0;
      drain_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else if (CLR_DP) begin
      icnt_q       <= '0;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      last_q       <= '0;
      base_q       <= '0;
      fetch_done_q <= 1'b0;
      drain_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      fetch_done_q <= 1'b0;
      drain_done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_ok) begin
          last_q <= last_idx(ROW_TOTAL);
          base_q <= BASE_ADDR;
          icnt_q <= '0;
          wcnt_q <= '0;
          rcnt_q <= '0;
          if (first_tile_w) begin
            fetch_done_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
          end
        end
        FETCH: icnt_q <= icnt_q + 1'b1;
        READY: if (POP) begin
          if (rcnt_q == last_q) begin
            rcnt_q       <= '0;
            drain_done_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
      // Captures follow issue order, so the pipe tag and wcnt agree.
      if (cap_valid) begin
        bank_q[cap_idx] <= RData;
        wcnt_q          <= wcnt_q + 1'b1;
        if (wcnt_q == last_q) fetch_done_q <= 1'b1;
      end
    end
  end

  assign FETCH_DONE = fetch_done_q;
  assign DRAIN_DONE = drain_done_q;
  assign PSUM_VALID = (state_q == READY);
  assign PSUM       = (state_q == READY) ? bank_q[rcnt_q] : '0;
  assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_psum_rbuffer.sv
// Bench for psum_rbuffer: two instances (read latency 1 and 3) against a memory model and row-list reference.
module tb_psum_rbuffer;

  logic        CLK, RST, CLR_DP, START, POP;
  logic [3:0]  BASE_ADDR;
  logic [2:0]  ROW_TOTAL;
`ifdef PSUM_RB_FIRST_TILE_EN
  logic        FIRST_TILE;
`endif
  logic [3:0]  osrc1, osrc3;
  logic        ren1, ren3, fd1, fd3, pv1, pv3, dd1, dd3, busy1, busy3;
  logic [63:0] rdata1, rdata3, psum1, psum3, junk1, junk3;

  logic [63:0] mem [16];
  logic        v1_q;
  logic [3:0]  a1_q;
  logic [2:0]  v3_q;
  logic [3:0]  a3_q [3];

  bit          sel;
  logic [3:0]  osrc_s;
  logic        ren_s, fd_s, pv_s, dd_s, busy_s;
  logic [63:0] psum_s;

  int          checks = 0, errors = 0;
  logic [3:0]  raddr[$];
  int          rcyc[$];
  logic [63:0] rows[$];
  int          fd_n, dd_n, fd_cyc, dd_cyc, last_pop;
  logic        pv_at_dd;
  bit          timed_out;

  psum_rbuffer #(.RD_LAT(1)) dut (
    .CLK(CLK), .RST(RST), .CLR_DP(CLR_DP), .START(START), .BASE_ADDR(BASE_ADDR),
    .ROW_TOTAL(ROW_TOTAL),
`ifdef PSUM_RB_FIRST_TILE_EN
    .FIRST_TILE(FIRST_TILE),
`endif
    .OSRC_rb(osrc1), .REN_rb(ren1), .RData(rdata1), .FETCH_DONE(fd1), .PSUM_VALID(pv1),
    .PSUM(psum1), .POP(POP), .DRAIN_DONE(dd1), .BUSY(busy1));

  psum_rbuffer #(.RD_LAT(3)) dut3 (
    .CLK(CLK), .RST(RST), .CLR_DP(CLR_DP), .START(START), .BASE_ADDR(BASE_ADDR),
    .ROW_TOTAL(ROW_TOTAL),
`ifdef PSUM_RB_FIRST_TILE_EN
    .FIRST_TILE(FIRST_TILE),
`endif
    .OSRC_rb(osrc3), .REN_rb(ren3), .RData(rdata3), .FETCH_DONE(fd3), .PSUM_VALID(pv3),
    .PSUM(psum3), .POP(POP), .DRAIN_DONE(dd3), .BUSY(busy3));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory read port: data valid exactly RD_LAT cycles after the enable, garbage otherwise.
  always @(posedge CLK) begin
    v1_q    <= ren1;
    a1_q    <= osrc1;
    v3_q    <= {v3_q[1:0], ren3};
    a3_q[2] <= a3_q[1];
    a3_q[1] <= a3_q[0];
    a3_q[0] <= osrc3;
    junk1   <= {$urandom, $urandom};
    junk3   <= {$urandom, $urandom};
  end
  assign rdata1 = v1_q    ? mem[a1_q]    : junk1;
  assign rdata3 = v3_q[2] ? mem[a3_q[2]] : junk3;

  always_comb begin
    osrc_s = sel ? osrc3 : osrc1;
    ren_s  = sel ? ren3  : ren1;
    fd_s   = sel ? fd3   : fd1;
    pv_s   = sel ? pv3   : pv1;
    dd_s   = sel ? dd3   : dd1;
    busy_s = sel ? busy3 : busy1;
    psum_s = sel ? psum3 : psum1;
  end

  // Runs one START..DRAIN_DONE transaction on the selected instance and records what it saw.
  // gap < 0 holds POP high every cycle; poke re-issues START together with the first POP.
  task automatic run_txn(input logic [3:0] base, input logic [2:0] total, input int gap, input bit poke);
    bit poked = 0;
    rows.delete(); raddr.delete(); rcyc.delete();
    fd_n = 0; dd_n = 0; fd_cyc = -1; dd_cyc = -1; last_pop = -10; pv_at_dd = 1'b1; timed_out = 0;
    @(negedge CLK);
    BASE_ADDR = base; ROW_TOTAL = total; START = 1'b1; POP = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge CLK);
      START = 1'b0; POP = 1'b0; BASE_ADDR = base;
      if (ren_s) begin raddr.push_back(osrc_s); rcyc.push_back(c); end
      if (fd_s) begin fd_n++; fd_cyc = c; end
      if (dd_s) begin dd_n++; dd_cyc = c; pv_at_dd = pv_s; break; end
      if (pv_s) begin
        if (poke && !poked) begin
          START = 1'b1; BASE_ADDR = base + 4'd8; ROW_TOTAL = 3'd2; poked = 1;
          POP = 1'b1; rows.push_back(psum_s); last_pop = c;
        end else if (gap < 0 || $urandom_range(0, gap) == 0) begin
          POP = 1'b1; rows.push_back(psum_s); last_pop = c;
        end
      end else if (gap < 0) begin
        POP = 1'b1;
      end
    end
    if (dd_n == 0) timed_out = 1;
    POP = 1'b0; START = 1'b0;
  endtask

  task automatic test_reset();
    logic [71:0] o1, o3;
    @(negedge CLK);
    o1 = {osrc1, ren1, fd1, pv1, dd1, busy1, psum1[61:0]};
    o3 = {osrc3, ren3, fd3, pv3, dd3, busy3, psum3[61:0]};
    checks++; if (o1 !== '0 || psum1 !== '0) begin errors++; $display("FAIL reset_lat1 got %h want 0", o1); end
    checks++; if (o3 !== '0 || psum3 !== '0) begin errors++; $display("FAIL reset_lat3 got %h want 0", o3); end
    RST = 1'b0;
    // Asynchronous reset in the middle of a fetch.
    sel = 0;
    for (int a = 0; a < 16; a++) mem[a] = 64'(a) * 64'h11;
    @(negedge CLK); BASE_ADDR = 4'd0; ROW_TOTAL = 3'd4; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    @(negedge CLK);
    RST = 1'b1; #1;
    checks++; if (busy1 !== 1'b0 || ren1 !== 1'b0) begin errors++; $display("FAIL reset_async busy=%b ren=%b want 0 0", busy1, ren1); end
    @(negedge CLK); RST = 1'b0;
    run_txn(4'd6, 3'd2, 0, 1'b0);
    checks++; if (rows.size() != 2 || rows[0] !== mem[6] || rows[1] !== mem[7])
      begin errors++; $display("FAIL reset_recover got %0d rows want 2 rows 66,77", rows.size()); end
  endtask

  task automatic test_basic();
    sel = 0;
    for (int a = 0; a < 16; a++) mem[a] = 64'(a) * 64'h11;
    run_txn(4'd2, 3'd4, 1, 1'b0);
    checks++; if (raddr.size() != 4) begin errors++; $display("FAIL basic_nreads got %0d want 4", raddr.size()); end
    for (int i = 0; i < raddr.size() && i < 4; i++) begin
      checks++;
      if (raddr[i] !== 4'(2 + i) || rcyc[i] != i + 1)
        begin errors++; $display("FAIL basic_addr[%0d] got %h@%0d want %h@%0d", i, raddr[i], rcyc[i], 4'(2 + i), i + 1); end
    end
    checks++; if (fd_n != 1 || fd_cyc != 6) begin errors++; $display("FAIL basic_fetch_done got n=%0d cyc=%0d want n=1 cyc=6", fd_n, fd_cyc); end
    checks++; if (rows.size() != 4) begin errors++; $display("FAIL basic_nrows got %0d want 4", rows.size()); end
    for (int i = 0; i < rows.size() && i < 4; i++) begin
      checks++;
      if (rows[i] !== 64'h22 + 64'(i) * 64'h11)
        begin errors++; $display("FAIL basic_psum[%0d] got %h want %h", i, rows[i], 64'h22 + 64'(i) * 64'h11); end
    end
    checks++; if (timed_out || dd_n != 1 || dd_cyc != last_pop + 1 || pv_at_dd !== 1'b0)
      begin errors++; $display("FAIL basic_drain got n=%0d cyc=%0d pv=%b want n=1 cyc=%0d pv=0", dd_n, dd_cyc, pv_at_dd, last_pop + 1); end
  endtask

  task automatic test_wrap();
    logic [3:0] want_a [3];
    want_a[0] = 4'd14; want_a[1] = 4'd15; want_a[2] = 4'd0;
    sel = 0;
    run_txn(4'd14, 3'd3, 2, 1'b0);
    checks++; if (raddr.size() != 3 || rows.size() != 3)
      begin errors++; $display("FAIL wrap_count got reads=%0d rows=%0d want 3 3", raddr.size(), rows.size()); end
    for (int i = 0; i < 3 && i < raddr.size() && i < rows.size(); i++) begin
      checks++;
      if (raddr[i] !== want_a[i] || rows[i] !== mem[want_a[i]])
        begin errors++; $display("FAIL wrap[%0d] got a=%h d=%h want a=%h d=%h", i, raddr[i], rows[i], want_a[i], mem[want_a[i]]); end
    end
  endtask

  task automatic test_lat3();
    sel = 1;
    run_txn(4'd5, 3'd2, -1, 1'b0);
    checks++; if (raddr.size() != 2 || fd_n != 1 || fd_cyc != rcyc[raddr.size() > 0 ? raddr.size() - 1 : 0] + 4)
      begin errors++; $display("FAIL lat3_fetch_done got reads=%0d n=%0d cyc=%0d want reads=2 n=1 cyc=6", raddr.size(), fd_n, fd_cyc); end
    checks++; if (rows.size() != 2 || rows[0] !== mem[5] || rows[1] !== mem[6])
      begin errors++; $display("FAIL lat3_rows got %0d rows want 2 rows %h %h", rows.size(), mem[5], mem[6]); end
    checks++; if (timed_out || dd_n != 1 || pv_at_dd !== 1'b0)
      begin errors++; $display("FAIL lat3_drain got n=%0d pv=%b want n=1 pv=0", dd_n, pv_at_dd); end
  endtask

  task automatic test_clear();
    int ren_n = 0, bad = 0;
    bit in_wait;
    sel = 1;
    @(negedge CLK); BASE_ADDR = 4'd0; ROW_TOTAL = 3'd4; START = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK); START = 1'b0;
      if (ren_s) ren_n++;
    end
    in_wait = busy_s && !ren_s;
    checks++; if (ren_n != 4 || !in_wait) begin errors++; $display("FAIL clear_setup got reads=%0d wait=%b want 4 1", ren_n, in_wait); end
    CLR_DP = 1'b1;
    @(negedge CLK); CLR_DP = 1'b0;
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL clear_idle got busy=%b want 0", busy_s); end
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (fd_s || pv_s || ren_s || busy_s) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_quiet got %0d active cycles want 0", bad); end
    run_txn(4'd9, 3'd3, 1, 1'b0);
    checks++; if (fd_n != 1 || rows.size() != 3 || rows[0] !== mem[9] || rows[1] !== mem[10] || rows[2] !== mem[11])
      begin errors++; $display("FAIL clear_restart got fd=%0d rows=%0d want fd=1 rows=3 (9,10,11)", fd_n, rows.size()); end
  endtask

  task automatic test_ignored();
    int act = 0;
    sel = 0;
    @(negedge CLK); BASE_ADDR = 4'd1; ROW_TOTAL = 3'd0; START = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK); START = 1'b0;
      if (ren_s || busy_s) act++;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL zero_total got %0d active cycles want 0", act); end
    act = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); POP = 1'b1;
      if (pv_s || dd_s || busy_s) act++;
    end
    @(negedge CLK); POP = 1'b0;
    if (pv_s || dd_s || busy_s) act++;
    checks++; if (act != 0) begin errors++; $display("FAIL idle_pop got %0d active cycles want 0", act); end
    run_txn(4'd3, 3'd3, 1, 1'b1);
    checks++; if (fd_n != 1 || dd_n != 1 || raddr.size() != 3)
      begin errors++; $display("FAIL ready_start got fd=%0d dd=%0d reads=%0d want 1 1 3", fd_n, dd_n, raddr.size()); end
    checks++; if (rows.size() != 3 || rows[0] !== mem[3] || rows[1] !== mem[4] || rows[2] !== mem[5])
      begin errors++; $display("FAIL ready_start_rows got %0d rows want 3 (3,4,5)", rows.size()); end
    @(negedge CLK);
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL ready_start_dropped got busy=%b want 0", busy_s); end
  endtask

  task automatic test_random();
    logic [3:0] base;
    logic [2:0] total;
    int n, ok_rows, ok_addr;
    for (int it = 0; it < 10; it++) begin
      sel = $urandom_range(0, 1) == 1;
      for (int a = 0; a < 16; a++) mem[a] = {$urandom, $urandom};
      base  = 4'($urandom_range(0, 15));
      total = (it == 0) ? 3'd7 : 3'($urandom_range(1, 7));
      n = (total > 3'd4) ? 4 : int'(total);
      run_txn(base, total, $urandom_range(0, 3), 1'b0);
      ok_addr = 0; ok_rows = 0;
      for (int i = 0; i < n && i < raddr.size(); i++)
        if (raddr[i] === base + 4'(i) && rcyc[i] == i + 1) ok_addr++;
      for (int i = 0; i < n && i < rows.size(); i++)
        if (rows[i] === mem[base + 4'(i)]) ok_rows++;
      checks++; if (raddr.size() != n || ok_addr != n)
        begin errors++; $display("FAIL rand%0d_reads got %0d/%0d good want %0d", it, ok_addr, raddr.size(), n); end
      checks++; if (rows.size() != n || ok_rows != n)
        begin errors++; $display("FAIL rand%0d_rows got %0d/%0d good want %0d", it, ok_rows, rows.size(), n); end
      checks++; if (fd_n != 1 || raddr.size() == 0 || fd_cyc != rcyc[raddr.size() > 0 ? raddr.size() - 1 : 0] + (sel ? 4 : 2))
        begin errors++; $display("FAIL rand%0d_fetch_done got n=%0d cyc=%0d want n=1 at last read+%0d", it, fd_n, fd_cyc, sel ? 4 : 2); end
      checks++; if (timed_out || dd_n != 1 || dd_cyc != last_pop + 1 || pv_at_dd !== 1'b0)
        begin errors++; $display("FAIL rand%0d_drain got n=%0d cyc=%0d want n=1 cyc=%0d", it, dd_n, dd_cyc, last_pop + 1); end
    end
  endtask

`ifdef PSUM_RB_FIRST_TILE_EN
  task automatic test_first_tile();
    int nz = 0;
    sel = 0;
    FIRST_TILE = 1'b1;
    run_txn(4'd5, 3'd4, 1, 1'b0);
    FIRST_TILE = 1'b0;
    for (int i = 0; i < rows.size(); i++) if (rows[i] !== 64'd0) nz++;
    checks++; if (raddr.size() != 0 || fd_n != 1 || fd_cyc != 1)
      begin errors++; $display("FAIL first_tile_fetch got reads=%0d fd=%0d cyc=%0d want 0 1 1", raddr.size(), fd_n, fd_cyc); end
    checks++; if (rows.size() != 4 || nz != 0 || dd_n != 1)
      begin errors++; $display("FAIL first_tile_rows got rows=%0d nonzero=%0d dd=%0d want 4 0 1", rows.size(), nz, dd_n); end
  endtask
`endif

  initial begin
    RST = 1'b1; CLR_DP = 1'b0; START = 1'b0; POP = 1'b0;
    BASE_ADDR = '0; ROW_TOTAL = '0; sel = 0;
`ifdef PSUM_RB_FIRST_TILE_EN
    FIRST_TILE = 1'b0;
`endif
    for (int a = 0; a < 16; a++) mem[a] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_lat3();
    test_clear();
    test_ignored();
    test_random();
`ifdef PSUM_RB_FIRST_TILE_EN
    test_first_tile();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
